// File: rtl/led_status_mux.sv
// led_status_mux: final LED drive stage of the UART sample design.
// Priority: error blink code > UART activity flash > heartbeat passthrough.
// led_out and busy are registered and reflect the state one cycle earlier.
module led_status_mux #(
   parameter int unsigned STRETCH_CYC   = 1_250_000,
   parameter int unsigned BLINK_ON_CYC  = 5_000_000,
   parameter int unsigned BLINK_OFF_CYC = 5_000_000,
   parameter int unsigned GAP_CYC       = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hb_in,
   input  logic       rx_strobe,
   input  logic       tx_strobe,
   input  logic [2:0] err_code,
   output logic       led_out,
   output logic       busy
);

   localparam int unsigned MaxBlink = (BLINK_ON_CYC > BLINK_OFF_CYC) ? BLINK_ON_CYC
                                                                      : BLINK_OFF_CYC;
   localparam int unsigned MaxPhase = (MaxBlink > GAP_CYC) ? MaxBlink : GAP_CYC;
   localparam int unsigned StretchW = $clog2(STRETCH_CYC + 1);
   localparam int unsigned TimerW   = $clog2(MaxPhase + 1);

   // Phase timers count from LEN-1 down to 0, so each phase lasts exactly LEN cycles.
   localparam logic [StretchW-1:0] StretchLoad = StretchW'(STRETCH_CYC);
   localparam logic [TimerW-1:0]   OnLoad      = TimerW'(BLINK_ON_CYC - 1);
   localparam logic [TimerW-1:0]   OffLoad     = TimerW'(BLINK_OFF_CYC - 1);
   localparam logic [TimerW-1:0]   GapLoad     = TimerW'(GAP_CYC - 1);

   typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

   state_e              state_q, state_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [2:0]          rem_q, rem_d;
   logic [StretchW-1:0] stretch_q, stretch_d;
   logic                led_q, led_d;
   logic                busy_q, busy_d;

   // Activity stretcher: any strobe reloads (retrigger, no accumulation), else count down.
   always_comb begin
      stretch_d = stretch_q;
      if (rx_strobe || tx_strobe) begin
         stretch_d = StretchLoad;
      end else if (stretch_q != '0) begin
         stretch_d = stretch_q - StretchW'(1);
      end
   end

   // Error blink FSM: err_code is only sampled in idle, so changes mid-sequence wait.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rem_d   = rem_q;
      unique case (state_q)
         StIdle: begin
            if (err_code != 3'd0) begin
               rem_d   = err_code;
               timer_d = OnLoad;
               state_d = StOn;
            end
         end
         StOn: begin
            if (timer_q == '0) begin
               timer_d = OffLoad;
               rem_d   = rem_q - 3'd1;
               state_d = StOff;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StOff: begin
            if (timer_q == '0) begin
               if (rem_q == 3'd0) begin
                  timer_d = GapLoad;
                  state_d = StGap;
               end else begin
                  timer_d = OnLoad;
                  state_d = StOn;
               end
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StGap: begin
            if (timer_q == '0) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output select from current state; flash inverts heartbeat so it shows in either phase.
   always_comb begin
      led_d  = hb_in;
      busy_d = (state_q != StIdle);
      unique case (state_q)
         StOn:         led_d = 1'b1;
         StOff, StGap: led_d = 1'b0;
         default:      led_d = (stretch_q != '0) ? ~hb_in : hb_in;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         rem_q     <= 3'd0;
         stretch_q <= '0;
         led_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         rem_q     <= rem_d;
         stretch_q <= stretch_d;
         led_q     <= led_d;
         busy_q    <= busy_d;
      end
   end

   assign led_out = led_q;
   assign busy    = busy_q;

endmodule

// File: doc/led_status_mux.md
# led_status_mux

Final LED output stage of the UART sample design. Consumes the free-running heartbeat level from the LED blink counter plus UART byte strobes and a 3-bit error code, and drives the single board LED. Priority: error blink code > UART activity flash > heartbeat. All inputs are in the `clk` domain (25 MHz).

## Interface
- `STRETCH_CYC`, default 1_250_000: activity flash length in cycles (50 ms).
- `BLINK_ON_CYC`, default 5_000_000: error pulse on-time (200 ms).
- `BLINK_OFF_CYC`, default 5_000_000: error pulse off-time (200 ms).
- `GAP_CYC`, default 25_000_000: dark gap after each error code (1 s).
- `clk` in 1: system clock, 25 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `hb_in` in 1: heartbeat level from the blink counter (its MSB).
- `rx_strobe` in 1: one-cycle pulse per received byte.
- `tx_strobe` in 1: one-cycle pulse per transmitted byte.
- `err_code` in 3: 0 = no error; 1..7 = number of blinks to show.
- `led_out` out 1: LED drive, active high, registered.
- `busy` out 1: high while an error sequence (ON/OFF/GAP) runs, registered.

## Operation
- Reset: `led_out`=0, `busy`=0, FSM=IDLE, all counters 0.
- Activity stretcher: a down counter of width `$clog2(STRETCH_CYC+1)`. Any cycle with `rx_strobe|tx_strobe` loads `STRETCH_CYC`. Otherwise it decrements while nonzero. Simultaneous rx/tx equals a single strobe. A strobe while the counter is nonzero reloads it (retrigger, no accumulation).
- Error FSM states: IDLE, ON, OFF, GAP. One shared phase timer, width `$clog2(max(BLINK_ON_CYC,BLINK_OFF_CYC,GAP_CYC)+1)`. A 3-bit remaining-blink count `rem`.
  - IDLE: if `err_code`≠0, latch `rem`=`err_code`, load timer=`BLINK_ON_CYC`-1, go ON.
  - ON: timer reaches 0 → load `BLINK_OFF_CYC`-1, `rem`=`rem`-1, go OFF.
  - OFF: timer reaches 0 → if `rem`=0, load `GAP_CYC`-1 and go GAP. Otherwise load `BLINK_ON_CYC`-1 and go ON.
  - GAP: timer reaches 0 → IDLE. The FSM re-samples `err_code` in IDLE, so a persistent error repeats with exactly one IDLE cycle between sequences.
  - `err_code` changes during ON/OFF/GAP are ignored until the next IDLE.
- Output select, with the next-cycle value computed from the current state:
  - FSM in ON: `led_out`=1.
  - FSM in OFF or GAP: `led_out`=0.
  - IDLE with stretch counter ≠0: `led_out`=~`hb_in`, so the flash is visible in either heartbeat phase.
  - IDLE with stretch counter =0: `led_out`=`hb_in`.
- `busy`=1 when the FSM is not in IDLE, registered the same way.
- The stretcher keeps running during an error sequence. If still nonzero when the FSM returns to IDLE, the flash shows for the remaining cycles.

## Timing
- `led_out`/`busy` lag the state/counter they reflect by one cycle.
- `err_code`≠0 sampled at edge k → ON from edge k+1 → `led_out`=1 from edge k+2.
- Each ON phase: `led_out` high for exactly `BLINK_ON_CYC` cycles. Each OFF: low for exactly `BLINK_OFF_CYC` cycles. GAP: low for `GAP_CYC` cycles.
- Full sequence for code n: n·(ON+OFF)+GAP cycles, plus 1 IDLE cycle before a repeat.
- Strobe at edge k → `led_out`=~`hb_in` from edge k+2, lasting `STRETCH_CYC` cycles after the last strobe.
- `hb_in` change in IDLE with no activity → `led_out` follows after 1 cycle.
- Reset asserted mid-sequence: immediate return to reset values. No sequence resumes after release unless `err_code`≠0.

## Test plan
(Sim parameters: `STRETCH_CYC`=4, `BLINK_ON_CYC`=3, `BLINK_OFF_CYC`=2, `GAP_CYC`=10.)
- Reset, `hb_in` toggling every 8 cycles, no strobes, `err_code`=0 → `led_out` equals `hb_in` delayed 1 cycle, `busy`=0 throughout.
- Single `rx_strobe` with `hb_in`=0 → `led_out`=1 for exactly 4 cycles starting 2 cycles after the strobe, then 0.
- `rx_strobe` and `tx_strobe` in the same cycle, then `tx_strobe` again 2 cycles later → one continuous inverted window of 6 cycles.
- `err_code`=3 held one cycle, then 0 → pattern 111 00 111 00 111 00 followed by 10 zeros. `busy` high for 25 cycles, then normal heartbeat.
- `err_code`=2 held constant → sequence of 20 cycles repeats with one IDLE cycle between sequences. Changing to 5 mid-sequence takes effect only on the next sequence.
- `rst_n` pulsed low during ON phase of `err_code`=7 → `led_out`=0 and `busy`=0 within the reset cycle. After release with `err_code`=0, heartbeat passthrough only.
